stall_ctrl: RTL and testbench
=============================

STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 63, maximum cycles to wait for md_ready before forcing release.
REQ-002 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port fd_ir  input  32  instruction held in the F/D latch.
REQ-005 SHALL have port dx_ir  input  32  instruction held in the D/X latch.
REQ-006 SHALL have port branch_taken  input  1  X stage resolved a taken branch or jump this cycle.
REQ-007 SHALL have port md_ready  input  1  multdiv unit result valid, single-cycle pulse.
REQ-008 SHALL have ports pc_we, fd_we, dx_we  output  1 each  write enables for the PC register, F/D latch and D/X latch.
REQ-009 SHALL have ports fd_flush, dx_bubble, xm_bubble  output  1 each  load NOP into F/D, D/X or X/M on the next edge.
REQ-010 SHALL have port md_start  output  1  one-cycle start pulse to the multdiv unit.
REQ-011 SHALL have port md_error  output  1  sticky flag: MD_TIMEOUT expired.

Function
REQ-012 SHALL decode ISA fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2].
REQ-013 SHALL treat dx_ir as mult/div when opcode=00000 and ALU op is 00110 (mul) or 00111 (div).
REQ-014 SHALL flag load-use when dx opcode=01000 (lw), dx rd != 0, and dx rd equals fd rs, equals fd rt (fd opcode 00000), or equals fd rd (fd opcode sw 00111, bne 00010, blt 00110, jr 00100).
REQ-015 SHALL implement FSM states RUN, MD_WAIT.
REQ-016 RUN, dx mult/div: assert md_start; pc_we=fd_we=dx_we=0; xm_bubble=1; next state MD_WAIT; clear cycle counter to 0.
REQ-017 MD_WAIT, md_ready=0: md_start=0; pc_we=fd_we=dx_we=0; xm_bubble=1; increment counter.
REQ-018 MD_WAIT, md_ready=1: all enables=1; xm_bubble=0; next state RUN (the result enters X/M that edge).
REQ-019 MD_WAIT, counter reaches MD_TIMEOUT without md_ready: set md_error; release as in REQ-018.
REQ-020 The first RUN cycle after MD_WAIT SHALL NOT re-trigger md_start for the same instruction.
REQ-021 RUN, branch_taken=1 (no mult/div in dx): pc_we=fd_we=dx_we=1; fd_flush=1; dx_bubble=1.
REQ-022 RUN, load-use, no branch_taken: pc_we=fd_we=0; dx_we=1; dx_bubble=1.
REQ-023 RUN, no event: all enables=1; all bubbles/flush=0.
REQ-024 Priority SHALL be: reset > mult/div stall > branch_taken > load-use.
REQ-025 Stall outputs SHALL be combinational from state and inputs; md_start, md_error and the counter SHALL be registered or state-derived.
REQ-026 Counter width SHALL be $clog2(MD_TIMEOUT+1); it SHALL saturate, never wrap.

Reset
REQ-027 Reset SHALL set state=RUN, counter=0, md_error=0 immediately.
REQ-028 While reset=1: pc_we=fd_we=dx_we=0, fd_flush=dx_bubble=xm_bubble=1, md_start=0.
REQ-029 Reset asserted in MD_WAIT SHALL abandon the operation; no md_start SHALL follow deassertion unless dx_ir again holds mult/div.

Structure
REQ-030 Opcode, ALU op and field-position constants, plus the state encoding, SHALL live in the shared CPU package.
REQ-031 A sub-module hazard_detect SHALL hold the combinational load-use compare (REQ-014); the FSM and counter SHALL stay in stall_ctrl.

Verification
REQ-032 dx_ir=mul r3,r1,r2; md_ready pulses on cycle 34 -> md_start high cycle 1 only; pc_we/fd_we/dx_we=0 cycles 1-33; all=1 cycle 34; no second md_start.
REQ-033 dx_ir=lw r5,0(r1), fd_ir=add r6,r5,r2 -> one cycle with pc_we=fd_we=0, dx_bubble=1; next cycle all enables=1.
REQ-034 dx_ir=lw r0,..., fd_ir=add r6,r0,r2 -> no stall.
REQ-035 branch_taken=1 with lw-use pattern present -> fd_flush=1, dx_bubble=1, pc_we=1 (branch wins).
REQ-036 dx_ir=div, md_ready never, MD_TIMEOUT=63 -> release and md_error=1 after 63 wait cycles; md_error stays 1 until reset.
REQ-037 Reset asserted mid-MD_WAIT -> state=RUN, md_error=0, outputs per REQ-028 without a clock edge.

Source files
------------

// File: rtl/stall_ctrl_pkg.sv
// stall_ctrl_pkg: shared CPU constants (instruction field positions, opcodes,
// ALU ops) and the stall controller state encoding.
package stall_ctrl_pkg;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 27;
    localparam int RD_HI  = 26;
    localparam int RD_LO  = 22;
    localparam int RS_HI  = 21;
    localparam int RS_LO  = 17;
    localparam int RT_HI  = 16;
    localparam int RT_LO  = 12;
    localparam int ALU_HI = 6;
    localparam int ALU_LO = 2;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

    function automatic logic is_md(input logic [4:0] op, input logic [4:0] alu);
        return op == OP_RTYPE && (alu == ALU_MUL || alu == ALU_DIV);
    endfunction

endpackage

// File: rtl/stall_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use compare between the D/X load and the F/D consumer.
//   fd_ir    - instruction in F/D (consumer)
//   dx_ir    - instruction in D/X (possible lw producer)
//   load_use - F/D reads the register the D/X lw is about to write
module hazard_detect
    import stall_ctrl_pkg::*;
(
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    output logic        load_use
);
    logic [4:0] fd_op, fd_rd, fd_rs, fd_rt, dx_op, dx_rd;
    logic       rd_src, unused_bits;

    assign fd_op = fd_ir[OP_HI:OP_LO];
    assign fd_rd = fd_ir[RD_HI:RD_LO];
    assign fd_rs = fd_ir[RS_HI:RS_LO];
    assign fd_rt = fd_ir[RT_HI:RT_LO];
    assign dx_op = dx_ir[OP_HI:OP_LO];
    assign dx_rd = dx_ir[RD_HI:RD_LO];

    // sw, bne, blt and jr read their rd field as a source operand
    assign rd_src = fd_op inside {OP_SW, OP_BNE, OP_BLT, OP_JR};

    // r0 is hardwired zero, so a load into it never creates a hazard
    assign load_use = dx_op == OP_LW && dx_rd != 5'd0 &&
                      (fd_rs == dx_rd || (fd_op == OP_RTYPE && fd_rt == dx_rd) ||
                       (rd_src && fd_rd == dx_rd));

    assign unused_bits = ^{fd_ir[11:0], dx_ir[21:0]};
endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline stall/flush controller for mult/div waits, taken branches and load-use.
//   clock, reset          - rising-edge clock, asynchronous active-high reset
//   fd_ir, dx_ir          - instructions in the F/D and D/X latches
//   branch_taken          - X stage resolved a taken branch/jump
//   md_ready              - multdiv result valid pulse
//   pc_we, fd_we, dx_we   - write enables for PC, F/D, D/X
//   fd_flush, dx_bubble, xm_bubble - load NOP into F/D, D/X, X/M on the next edge
//   md_start              - one-cycle multdiv start pulse
//   md_error              - sticky multdiv timeout flag
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 63
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    input  logic        branch_taken,
    input  logic        md_ready,
    output logic        pc_we,
    output logic        fd_we,
    output logic        dx_we,
    output logic        fd_flush,
    output logic        dx_bubble,
    output logic        xm_bubble,
    output logic        md_start,
    output logic        md_error
);
    localparam int CW = $clog2(MD_TIMEOUT + 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          done, load_use, md_hit, timeout, release_md;

    hazard_detect u_hazard_detect (
        .fd_ir    (fd_ir),
        .dx_ir    (dx_ir),
        .load_use (load_use)
    );

    // done masks the mult/div still sitting in D/X on the cycle right after release
    assign md_hit     = is_md(dx_ir[OP_HI:OP_LO], dx_ir[ALU_HI:ALU_LO]) && !done;
    assign timeout    = cnt == CW'(MD_TIMEOUT);
    assign release_md = state == MD_WAIT && (md_ready || timeout);

    always_comb begin
        state_nx  = state;
        pc_we     = 1'b1;
        fd_we     = 1'b1;
        dx_we     = 1'b1;
        fd_flush  = 1'b0;
        dx_bubble = 1'b0;
        xm_bubble = 1'b0;
        md_start  = 1'b0;
        if (reset) begin
            {pc_we, fd_we, dx_we}            = 3'b000;
            {fd_flush, dx_bubble, xm_bubble} = 3'b111;
        end else if (state == MD_WAIT) begin
            if (release_md) state_nx = RUN;
            else begin
                {pc_we, fd_we, dx_we} = 3'b000;
                xm_bubble             = 1'b1;
            end
        end else if (md_hit) begin
            md_start              = 1'b1;
            {pc_we, fd_we, dx_we} = 3'b000;
            xm_bubble             = 1'b1;
            state_nx              = MD_WAIT;
        end else if (branch_taken) begin
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
        end else if (load_use) begin
            {pc_we, fd_we} = 2'b00;
            dx_bubble      = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            cnt      <= '0;
            done     <= 1'b0;
            md_error <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= state == RUN ? '0 : (md_ready || timeout) ? cnt : cnt + 1'b1;
            done     <= release_md;
            md_error <= md_error | (state == MD_WAIT && timeout && !md_ready);
        end
    end
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed stimulus, behavioural model and per-cycle compare for stall_ctrl.
module tb_stall_ctrl;
    localparam int TMO = 63;
    localparam logic [6:0] RUNV  = 7'b1110000;
    localparam logic [6:0] RSTV  = 7'b0001110;
    localparam logic [6:0] MDS   = 7'b0000011;
    localparam logic [6:0] WAITV = 7'b0000010;
    localparam logic [6:0] BRV   = 7'b1111100;
    localparam logic [6:0] LUV   = 7'b0010100;

    logic        clock, reset, branch_taken, md_ready;
    logic [31:0] fd_ir, dx_ir;
    logic        pc_we, fd_we, dx_we, fd_flush, dx_bubble, xm_bubble, md_start, md_error;
    logic [6:0]  outs;

    int errors = 0;
    int checks = 0;

    stall_ctrl #(.MD_TIMEOUT(TMO)) dut (
        .clock        (clock),
        .reset        (reset),
        .fd_ir        (fd_ir),
        .dx_ir        (dx_ir),
        .branch_taken (branch_taken),
        .md_ready     (md_ready),
        .pc_we        (pc_we),
        .fd_we        (fd_we),
        .dx_we        (dx_we),
        .fd_flush     (fd_flush),
        .dx_bubble    (dx_bubble),
        .xm_bubble    (xm_bubble),
        .md_start     (md_start),
        .md_error     (md_error)
    );

    assign outs = {pc_we, fd_we, dx_we, fd_flush, dx_bubble, xm_bubble, md_start};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] r_type(input int rd, input int rs, input int rt, input int alu);
        return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(alu), 2'd0};
    endfunction

    function automatic logic [31:0] i_type(input int op, input int rd, input int rs, input int imm);
        return {5'(op), 5'(rd), 5'(rs), 17'(imm)};
    endfunction

    function automatic int fld(input logic [31:0] ir, input int lo);
        return int'(ir >> lo) & 31;
    endfunction

    function automatic bit model_md(input logic [31:0] ir);
        return fld(ir, 27) == 0 && (fld(ir, 2) == 6 || fld(ir, 2) == 7);
    endfunction

    // a lw into a nonzero register stalls any following instruction that reads it
    function automatic bit model_lu(input logic [31:0] f, input logic [31:0] d);
        int fop, drd;
        bit reads;
        fop   = fld(f, 27);
        drd   = fld(d, 22);
        reads = fld(f, 17) == drd || (fop == 0 && fld(f, 12) == drd) ||
                ((fop == 7 || fop == 2 || fop == 6 || fop == 4) && fld(f, 22) == drd);
        return fld(d, 27) == 8 && drd != 0 && reads;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // model: an outstanding multdiv op, how long it has waited, sticky error, just-released flag
    bit m_wait, m_err, m_just;
    int m_waited;

    always @(negedge clock) begin
        logic [6:0] e;
        bit         e_err, rel;
        e_err = m_err;
        if (reset) begin
            e = RSTV;
            e_err = 1'b0;
            {m_wait, m_err, m_just} = 3'b000;
            m_waited = 0;
        end else if (m_wait) begin
            rel = md_ready || m_waited == TMO;
            e = rel ? RUNV : WAITV;
            if (rel) begin
                m_wait = 1'b0;
                m_just = 1'b1;
                if (!md_ready) m_err = 1'b1;
            end else m_waited++;
        end else begin
            if (model_md(dx_ir) && !m_just) begin
                e = MDS;
                m_wait = 1'b1;
                m_waited = 0;
            end else if (branch_taken) e = BRV;
            else if (model_lu(fd_ir, dx_ir)) e = LUV;
            else e = RUNV;
            m_just = 1'b0;
        end
        chk("model_outs", int'(outs), int'(e));
        chk("model_md_error", int'(md_error), int'(e_err));
    end

    task automatic cyc(input logic [6:0] e, input string name);
        @(negedge clock);
        chk(name, int'(outs), int'(e));
        @(posedge clock);
        #1;
    endtask

    initial begin
        int starts, stalls;
        bit released;
        logic [31:0] lw5, add_use, mul, div;
        lw5     = i_type(8, 5, 1, 0);
        add_use = r_type(6, 5, 2, 0);
        mul     = r_type(3, 1, 2, 6);
        div     = r_type(4, 1, 2, 7);
        reset = 1'b1;
        fd_ir = '0;
        dx_ir = '0;
        branch_taken = 1'b0;
        md_ready = 1'b0;
        @(negedge clock);
        chk("reset_outs", int'(outs), int'(RSTV));
        chk("reset_err", int'(md_error), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        cyc(RUNV, "idle");
        dx_ir = lw5; fd_ir = add_use;
        cyc(LUV, "lu_rs");
        dx_ir = '0;
        cyc(RUNV, "lu_after");
        dx_ir = lw5; fd_ir = r_type(6, 2, 5, 0);
        cyc(LUV, "lu_rt");
        fd_ir = i_type(7, 5, 1, 0);
        cyc(LUV, "lu_sw_rd");
        fd_ir = i_type(5, 5, 1, 0);
        cyc(RUNV, "addi_rd_no_lu");
        dx_ir = i_type(8, 0, 1, 0); fd_ir = r_type(6, 0, 2, 0);
        cyc(RUNV, "lw_r0");
        dx_ir = lw5; fd_ir = add_use; branch_taken = 1'b1;
        cyc(BRV, "branch_wins");
        branch_taken = 1'b0; dx_ir = '0; fd_ir = '0;
        cyc(RUNV, "idle2");
        dx_ir = mul; starts = 0; stalls = 0;
        for (int c = 1; c <= 35; c++) begin
            md_ready = c == 34;
            @(negedge clock);
            starts += int'(md_start);
            stalls += int'(!pc_we && !fd_we && !dx_we);
            if (c == 1) chk("mul_c1", int'(outs), int'(MDS));
            if (c == 34) chk("mul_c34", int'(outs), int'(RUNV));
            if (c == 35) chk("mul_no_retrigger", int'(outs), int'(RUNV));
            @(posedge clock);
            #1;
        end
        chk("mul_starts", starts, 1);
        chk("mul_stalls", stalls, 33);
        md_ready = 1'b0; dx_ir = '0;
        cyc(RUNV, "idle3");
        dx_ir = div; branch_taken = 1'b1;
        cyc(MDS, "md_over_branch");
        branch_taken = 1'b0; md_ready = 1'b1;
        cyc(RUNV, "div_ready");
        md_ready = 1'b0; dx_ir = '0;
        cyc(RUNV, "idle4");
        dx_ir = div; stalls = 0; released = 1'b0;
        for (int i = 0; i < 100 && !released; i++) begin
            @(negedge clock);
            if (pc_we) released = 1'b1;
            else stalls++;
            @(posedge clock);
            #1;
        end
        chk("timeout_release", int'(released), 1);
        chk("timeout_stalls", stalls, 64);
        dx_ir = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("err_sticky", int'(md_error), 1);
            @(posedge clock);
            #1;
        end
        dx_ir = mul;
        cyc(MDS, "mul2_start");
        cyc(WAITV, "mul2_wait1");
        cyc(WAITV, "mul2_wait2");
        #2 reset = 1'b1;
        #1;
        chk("async_rst_outs", int'(outs), int'(RSTV));
        chk("async_rst_err", int'(md_error), 0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        cyc(MDS, "mul_after_rst");
        md_ready = 1'b1;
        cyc(RUNV, "mul_after_rst_rel");
        md_ready = 1'b0; dx_ir = '0;
        cyc(RUNV, "tail");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
